i2c_slave_rx: RTL and testbench

I2C_SLAVE_RX -- requirements
Module: i2c_slave_rx

---
 rtl/i2c_slave_rx.sv | 245 ++++++++++++++++++++++++
 tb/tb_i2c_slave_rx.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_rx.sv
// ---------------------------------------------------------------------------
// i2c_slave_rx
//
// Write-only I2C slave receiver. Watches the raw SCL/SDA lines, answers its
// 7-bit address on write transfers, ACKs every data byte and packs the bytes
// big-endian into DATA_WIDTH-bit words that are handed downstream with a
// one-clock write strobe.
//
// Parameters
//   DATA_WIDTH : width of the assembled word (multiple of 8, 8..64)
//   SLAVE_ADDR : 7-bit I2C address this slave answers
//
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous reset, active low
//   scl        : raw I2C clock line (asynchronous to clk)
//   sda_in     : raw I2C data line (asynchronous to clk)
//   sda_pull   : 1 = pull SDA low (open drain), 0 = release
//   wr         : one-clock strobe, data_out holds a complete word
//   data_out   : last assembled word, held until the next wr
//   busy       : high from an accepted address until STOP / START
//   frame_err  : one-clock pulse when a partial word is thrown away
// ---------------------------------------------------------------------------
module i2c_slave_rx #(
  parameter int         DATA_WIDTH = 32,
  parameter logic [6:0] SLAVE_ADDR = 7'h47
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl,
  input  logic                  sda_in,
  output logic                  sda_pull,
  output logic                  wr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  frame_err
);

  localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
  localparam int BC_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(BYTES_PER_WORD - 1);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ADDR     = 3'd1;
  localparam logic [2:0] ST_ADDR_ACK = 3'd2;
  localparam logic [2:0] ST_DATA     = 3'd3;
  localparam logic [2:0] ST_DATA_ACK = 3'd4;
  localparam logic [2:0] ST_IGNORE   = 3'd5;

  // Line synchronisers: two flops for metastability, a third holding the
  // previous synced value so edges and START/STOP can be seen.
  logic sclMeta_q, sclSync_q, sclPrev_q;
  logic sdaMeta_q, sdaSync_q, sdaPrev_q;

  // Protocol state
  logic [2:0]            state_q,    state_d;
  logic [2:0]            bitCnt_q,   bitCnt_d;
  logic [7:0]            shiftReg_q, shiftReg_d;
  logic [BC_W-1:0]       byteCnt_q,  byteCnt_d;
  logic [DATA_WIDTH-1:0] wordBuf_q,  wordBuf_d;
  logic                  ackArmed_q, ackArmed_d;

  // Registered outputs
  logic                  sdaPull_q,  sdaPull_d;
  logic                  wr_q,       wr_d;
  logic [DATA_WIDTH-1:0] dataOut_q,  dataOut_d;
  logic                  busy_q,     busy_d;
  logic                  frameErr_q, frameErr_d;

  // Bus events derived from the synchronised lines
  logic                  sclRise, sclFall, startDet, stopDet;
  logic [7:0]            rxByte;
  logic [DATA_WIDTH-1:0] wordNext;
  logic                  partialWord;

  // Both raw lines pass through the synchroniser chain. Reset loads ones
  // so an idle (pulled-up) bus produces no edges or conditions when the
  // block comes out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclMeta_q <= 1'b1;
      sclSync_q <= 1'b1;
      sclPrev_q <= 1'b1;
      sdaMeta_q <= 1'b1;
      sdaSync_q <= 1'b1;
      sdaPrev_q <= 1'b1;
    end else begin
      sclMeta_q <= scl;
      sclSync_q <= sclMeta_q;
      sclPrev_q <= sclSync_q;
      sdaMeta_q <= sda_in;
      sdaSync_q <= sdaMeta_q;
      sdaPrev_q <= sdaSync_q;
    end
  end

  // Edge and bus-condition decode. A START/STOP is an SDA transition while
  // SCL is high; ordinary data only changes while SCL is low.
  assign sclRise  = sclSync_q & ~sclPrev_q;
  assign sclFall  = ~sclSync_q & sclPrev_q;
  assign startDet = sclSync_q & sdaPrev_q & ~sdaSync_q;
  assign stopDet  = sclSync_q & ~sdaPrev_q & sdaSync_q;

  // The byte as it will look once the current SDA bit is shifted in, and
  // the word buffer with that byte appended at the low end (big-endian).
  assign rxByte   = {shiftReg_q[6:0], sdaSync_q};
  assign wordNext = (wordBuf_q << 8) | DATA_WIDTH'(rxByte);

  // A word is only partially filled if at least one byte of it has been
  // received inside an accepted data phase.
  assign partialWord = ((state_q == ST_DATA) || (state_q == ST_DATA_ACK)) &&
                       (byteCnt_q != '0);

  // Next-state logic. START and STOP take priority over everything else so
  // they are honoured in every state, including the middle of an ACK bit,
  // where sda_pull drops on the same edge as the state change.
  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q;
    shiftReg_d = shiftReg_q;
    byteCnt_d  = byteCnt_q;
    wordBuf_d  = wordBuf_q;
    ackArmed_d = ackArmed_q;
    sdaPull_d  = sdaPull_q;
    wr_d       = 1'b0;
    dataOut_d  = dataOut_q;
    busy_d     = busy_q;
    frameErr_d = 1'b0;

    if (stopDet || startDet) begin
      state_d    = stopDet ? ST_IDLE : ST_ADDR;
      bitCnt_d   = '0;
      byteCnt_d  = '0;
      ackArmed_d = 1'b0;
      sdaPull_d  = 1'b0;
      busy_d     = 1'b0;
      frameErr_d = partialWord;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Nothing but a START leaves idle; handled above.
        end

        ST_ADDR: begin
          if (sclRise) begin
            shiftReg_d = rxByte;
            if (bitCnt_q == 3'd7) begin
              bitCnt_d = '0;
              // Only a write to our own address is acknowledged.
              if ((rxByte[7:1] == SLAVE_ADDR) && !rxByte[0]) begin
                state_d = ST_ADDR_ACK;
                busy_d  = 1'b1;
              end else begin
                state_d = ST_IGNORE;
              end
            end else begin
              bitCnt_d = bitCnt_q + 3'd1;
            end
          end
        end

        ST_ADDR_ACK, ST_DATA_ACK: begin
          // First SCL fall after bit 8 starts the ACK slot, the following
          // fall (end of the ninth clock) ends it.
          if (sclFall) begin
            if (!ackArmed_q) begin
              sdaPull_d  = 1'b1;
              ackArmed_d = 1'b1;
            end else begin
              sdaPull_d  = 1'b0;
              ackArmed_d = 1'b0;
              state_d    = ST_DATA;
              bitCnt_d   = '0;
            end
          end
        end

        ST_DATA: begin
          if (sclRise) begin
            shiftReg_d = rxByte;
            if (bitCnt_q == 3'd7) begin
              bitCnt_d  = '0;
              state_d   = ST_DATA_ACK;
              wordBuf_d = wordNext;
              if (byteCnt_q == LAST_BYTE) begin
                wr_d      = 1'b1;
                dataOut_d = wordNext;
                byteCnt_d = '0;
              end else begin
                byteCnt_d = byteCnt_q + 1'b1;
              end
            end else begin
              bitCnt_d = bitCnt_q + 3'd1;
            end
          end
        end

        ST_IGNORE: begin
          // Not addressed: stay silent until START or STOP.
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers. Reset returns everything to an idle,
  // silent slave with an empty output word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      bitCnt_q   <= '0;
      shiftReg_q <= '0;
      byteCnt_q  <= '0;
      wordBuf_q  <= '0;
      ackArmed_q <= 1'b0;
      sdaPull_q  <= 1'b0;
      wr_q       <= 1'b0;
      dataOut_q  <= '0;
      busy_q     <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      shiftReg_q <= shiftReg_d;
      byteCnt_q  <= byteCnt_d;
      wordBuf_q  <= wordBuf_d;
      ackArmed_q <= ackArmed_d;
      sdaPull_q  <= sdaPull_d;
      wr_q       <= wr_d;
      dataOut_q  <= dataOut_d;
      busy_q     <= busy_d;
      frameErr_q <= frameErr_d;
    end
  end

  assign sda_pull  = sdaPull_q;
  assign wr        = wr_q;
  assign data_out  = dataOut_q;
  assign busy      = busy_q;
  assign frame_err = frameErr_q;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave_rx
//
// Drives an I2C master on scl/sda_in (open-drain line shared with the DUT's
// sda_pull) and checks the slave against a transaction-level model: the
// model tracks which words a transfer must produce and whether a partial
// word is left when START/STOP arrives. A monitor compares wr/data_out and
// counts frame_err, sda_pull and busy cycles on every clock.
// ---------------------------------------------------------------------------
module tb_i2c_slave_rx;

  localparam int         DW   = 32;
  localparam logic [6:0] ADDR = 7'h47;
  localparam int         NB   = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          scl;
  logic          sdaDrv;
  logic          sda_in;
  logic          sda_pull;
  logic          wr;
  logic [DW-1:0] data_out;
  logic          busy;
  logic          frame_err;

  // Open-drain bus: the line is low if either side pulls it.
  assign sda_in = sdaDrv & ~sda_pull;

  always #5 clk = ~clk;

  i2c_slave_rx #(
    .DATA_WIDTH (DW),
    .SLAVE_ADDR (ADDR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda_in    (sda_in),
    .sda_pull  (sda_pull),
    .wr        (wr),
    .data_out  (data_out),
    .busy      (busy),
    .frame_err (frame_err)
  );

  int compared   = 0;
  int mismatched = 0;

  // Bus timing in clk periods, re-randomised per transfer
  int hiT = 6;
  int loT = 10;
  bit busIdle = 1'b1;

  // Transaction-level model
  logic [DW-1:0] expWordQ[$];
  logic [DW-1:0] mWord = '0;
  int            mBytes = 0;
  bit            mAccepted = 1'b0;
  int            expFe = 0;

  // Monitor statistics
  logic [DW-1:0] heldWord = '0;
  logic [DW-1:0] lastWr = '0;
  int            wrCnt = 0;
  int            feCnt = 0;
  int            pullCnt = 0;
  int            busyCnt = 0;
  logic          wrPrev = 1'b0;
  logic          fePrev = 1'b0;

  logic [7:0]    txBytes[$];

  // Every comparison funnels through here.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual,
               expected, $time);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Per-cycle monitor: words leave in order, data_out holds between
  // strobes, and wr/frame_err never last more than one clock.
  task automatic monitorLoop();
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        heldWord = '0;
        wrPrev   = 1'b0;
        fePrev   = 1'b0;
      end else begin
        if (wr) begin
          wrCnt++;
          lastWr = data_out;
          if (expWordQ.size() == 0) begin
            checkOutput("wr_without_word", 64'(wr), 64'(0));
          end else begin
            e = expWordQ.pop_front();
            checkOutput("wr_word", 64'(data_out), 64'(e));
            heldWord = e;
          end
        end else begin
          checkOutput("data_out_hold", 64'(data_out), 64'(heldWord));
        end
        checkOutput("wr_single_clk", 64'(wr & wrPrev), 64'(0));
        checkOutput("frame_err_single_clk", 64'(frame_err & fePrev), 64'(0));
        if (frame_err) feCnt++;
        if (sda_pull)  pullCnt++;
        if (busy)      busyCnt++;
        wrPrev = wr;
        fePrev = frame_err;
      end
    end
  endtask

  // Model: a received data byte in an accepted transfer
  task automatic modelByte(input logic [7:0] b);
    mWord = (mWord << 8) | DW'(b);
    mBytes++;
    if (mBytes == NB) begin
      expWordQ.push_back(mWord);
      mBytes = 0;
      mWord  = '0;
    end
  endtask

  // Model: START or STOP ends the frame; leftover bytes are an error
  task automatic modelBoundary();
    if (mAccepted && mBytes != 0) expFe++;
    mBytes    = 0;
    mWord     = '0;
    mAccepted = 1'b0;
  endtask

  // One data bit, entered and left with SCL low
  task automatic sendBit(input logic b);
    waitClk(loT / 2);
    sdaDrv = b;
    waitClk(loT - loT / 2);
    scl = 1'b1;
    waitClk(hiT / 2);
    checkOutput("pull_released_in_bit", 64'(sda_pull), 64'(0));
    waitClk(hiT - hiT / 2);
    scl = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) sendBit(b[i]);
  endtask

  // Ninth clock: master releases SDA, the slave may ACK
  task automatic ackBit(input bit expAck, input string name);
    waitClk(loT / 2);
    sdaDrv = 1'b1;
    waitClk(loT - loT / 2);
    scl = 1'b1;
    waitClk(hiT / 2);
    checkOutput(name, 64'(sda_pull), 64'(expAck));
    checkOutput({name, "_busy"}, 64'(busy), 64'(mAccepted));
    waitClk(hiT - hiT / 2);
    scl = 1'b0;
  endtask

  task automatic startCond();
    modelBoundary();
    if (busIdle) begin
      waitClk(hiT);
      sdaDrv = 1'b0;
      waitClk(hiT);
      scl = 1'b0;
    end else begin
      waitClk(loT / 2);
      sdaDrv = 1'b1;
      waitClk(loT - loT / 2);
      scl = 1'b1;
      waitClk(hiT / 2);
      sdaDrv = 1'b0;
      waitClk(hiT - hiT / 2);
      scl = 1'b0;
    end
    busIdle = 1'b0;
  endtask

  task automatic stopCond();
    modelBoundary();
    waitClk(loT / 2);
    sdaDrv = 1'b0;
    waitClk(loT - loT / 2);
    scl = 1'b1;
    waitClk(hiT / 2);
    sdaDrv = 1'b1;
    waitClk(hiT);
    busIdle = 1'b1;
    waitClk(6);
    checkOutput("busy_after_stop", 64'(busy), 64'(0));
    checkOutput("pull_after_stop", 64'(sda_pull), 64'(0));
    checkOutput("words_outstanding", 64'(expWordQ.size()), 64'(0));
    checkOutput("frame_err_count", 64'(feCnt), 64'(expFe));
  endtask

  // One transfer: (repeated) START, address, txBytes, optional stray bits,
  // optional STOP. Without STOP the next transfer opens with repeated START.
  task automatic applyStimulus(input logic [7:0] addrByte, input int partialBits,
                               input bit endStop);
    hiT = $urandom_range(4, 10);
    loT = $urandom_range(8, 12);
    startCond();
    sendByte(addrByte);
    mAccepted = (addrByte == {ADDR, 1'b0});
    ackBit(mAccepted, "addr_ack");
    foreach (txBytes[k]) begin
      for (int i = 7; i >= 1; i--) sendBit(txBytes[k][i]);
      if (mAccepted) modelByte(txBytes[k]);
      sendBit(txBytes[k][0]);
      ackBit(mAccepted, "data_ack");
    end
    for (int i = 0; i < partialBits; i++) sendBit(1'($urandom_range(0, 1)));
    if (endStop) stopCond();
  endtask

  initial begin
    int w0, f0, p0, b0;
    logic [7:0] a;
    int nData, partial;
    bit endStop;

    rst    = 1'b0;
    scl    = 1'b1;
    sdaDrv = 1'b1;
    fork
      monitorLoop();
    join_none

    waitClk(4);
    checkOutput("reset_sda_pull", 64'(sda_pull), 64'(0));
    checkOutput("reset_wr", 64'(wr), 64'(0));
    checkOutput("reset_data_out", 64'(data_out), 64'(0));
    checkOutput("reset_busy", 64'(busy), 64'(0));
    checkOutput("reset_frame_err", 64'(frame_err), 64'(0));
    rst = 1'b1;
    waitClk(4);

    // Single complete word
    w0 = wrCnt; f0 = feCnt; p0 = pullCnt;
    txBytes = '{8'h00, 8'h11, 8'h22, 8'h33};
    applyStimulus(8'h8E, 0, 1'b1);
    checkOutput("t030_wr_count", 64'(wrCnt - w0), 64'(1));
    checkOutput("t030_word", 64'(lastWr), 64'(32'h00112233));
    checkOutput("t030_frame_err", 64'(feCnt - f0), 64'(0));
    checkOutput("t030_pull_seen", 64'(pullCnt > p0), 64'(1));

    // Someone else's address
    w0 = wrCnt; p0 = pullCnt; b0 = busyCnt;
    txBytes = '{8'h44, 8'h55};
    applyStimulus(8'h24, 0, 1'b1);
    checkOutput("t031_pull_cycles", 64'(pullCnt - p0), 64'(0));
    checkOutput("t031_wr_count", 64'(wrCnt - w0), 64'(0));
    checkOutput("t031_busy_cycles", 64'(busyCnt - b0), 64'(0));

    // Our address with the read bit set
    w0 = wrCnt; p0 = pullCnt;
    txBytes.delete();
    applyStimulus(8'h8F, 0, 1'b1);
    checkOutput("t032_pull_cycles", 64'(pullCnt - p0), 64'(0));
    checkOutput("t032_wr_count", 64'(wrCnt - w0), 64'(0));

    // One word plus two stray bytes
    w0 = wrCnt; f0 = feCnt;
    txBytes = '{8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
    applyStimulus(8'h8E, 0, 1'b1);
    checkOutput("t033_wr_count", 64'(wrCnt - w0), 64'(1));
    checkOutput("t033_word", 64'(lastWr), 64'(32'h44556677));
    checkOutput("t033_frame_err", 64'(feCnt - f0), 64'(1));
    checkOutput("t033_data_out_held", 64'(data_out), 64'(32'h44556677));

    // Partial word cut short by a repeated START
    w0 = wrCnt; f0 = feCnt;
    txBytes = '{8'hAA, 8'hBB};
    applyStimulus(8'h8E, 0, 1'b0);
    txBytes = '{8'hCC, 8'hDD, 8'hEE, 8'hFF};
    applyStimulus(8'h8E, 0, 1'b1);
    checkOutput("t034_wr_count", 64'(wrCnt - w0), 64'(1));
    checkOutput("t034_word", 64'(lastWr), 64'(32'hCCDDEEFF));
    checkOutput("t034_frame_err", 64'(feCnt - f0), 64'(1));

    // Reset in the middle of a data byte
    w0 = wrCnt; f0 = feCnt;
    startCond();
    sendByte(8'h8E);
    mAccepted = 1'b1;
    ackBit(1'b1, "rst_addr_ack");
    sendByte(8'hAB);
    modelByte(8'hAB);
    ackBit(1'b1, "rst_data_ack");
    for (int i = 0; i < 4; i++) sendBit(1'(i & 1));
    rst = 1'b0;
    #2;
    checkOutput("rst_async_busy", 64'(busy), 64'(0));
    waitClk(2);
    checkOutput("rst_mid_sda_pull", 64'(sda_pull), 64'(0));
    checkOutput("rst_mid_wr", 64'(wr), 64'(0));
    checkOutput("rst_mid_data_out", 64'(data_out), 64'(0));
    checkOutput("rst_mid_frame_err", 64'(frame_err), 64'(0));
    scl    = 1'b1;
    sdaDrv = 1'b1;
    waitClk(4);
    mBytes = 0; mWord = '0; mAccepted = 1'b0;
    busIdle = 1'b1;
    rst = 1'b1;
    waitClk(8);
    checkOutput("rst_no_wr", 64'(wrCnt - w0), 64'(0));
    checkOutput("rst_no_frame_err", 64'(feCnt - f0), 64'(0));
    txBytes = '{8'h01, 8'h02, 8'h03, 8'h04};
    applyStimulus(8'h8E, 0, 1'b1);
    checkOutput("t035_wr_count", 64'(wrCnt - w0), 64'(1));
    checkOutput("t035_word", 64'(lastWr), 64'(32'h01020304));

    // Randomised transfers
    for (int t = 0; t < 20; t++) begin
      if ($urandom_range(0, 9) < 7) a = 8'h8E;
      else                          a = 8'($urandom);
      nData = $urandom_range(0, 7);
      txBytes.delete();
      for (int i = 0; i < nData; i++) txBytes.push_back(8'($urandom));
      partial = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
      endStop = ($urandom_range(0, 4) != 0);
      applyStimulus(a, partial, endStop);
    end
    if (!busIdle) stopCond();

    checkOutput("final_frame_err_count", 64'(feCnt), 64'(expFe));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
